// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, phase-count constants and stretch-phase helper for the I2C byte engine
package i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_A,
    ST_START_B,
    ST_START_C,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_BIT_FALL,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_ACK_FALL,
    ST_STOP_A,
    ST_STOP_B,
    ST_STOP_C,
    ST_DONE
  } i2c_state_t;
  localparam int PHASES_START = 3;
  localparam int PHASES_BYTE  = 24;
  localparam int PHASES_ACK   = 3;
  localparam int PHASES_STOP  = 3;
  function automatic logic is_stretch_phase(input i2c_state_t s);
    return s inside {ST_START_A, ST_BIT_HIGH, ST_ACK_HIGH, ST_STOP_B};
  endfunction
endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: counts CLK_DIV cycles per bus phase and freezes while a slave holds SCL low
module i2c_phase_timer #(
  parameter int CLK_DIV   = 36,
  parameter int DIV_WIDTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  input  logic i_load,
  input  logic i_hold,
  output logic o_phase_end
);
  logic [DIV_WIDTH-1:0] r_cnt;
  assign o_phase_end = i_run && (r_cnt == '0) && !i_hold;
  // reload on phase entry, otherwise count down unless the phase is being stretched
  always_ff @(posedge clock or posedge reset)
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= DIV_WIDTH'(CLK_DIV - 1);
    else if (r_cnt != '0 && !i_hold) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/i2c_master_byte.sv
// i2c_master_byte: one command per handshake (optional START, byte write/read, ACK/NACK, optional STOP); define I2C_CLOCK_STRETCH_EN to honour SCL stretching
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 36,
  parameter int DIV_WIDTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_nack,
  input  logic [7:0] write_byte,
  output logic [7:0] read_byte,
  output logic       done,
  output logic       ack_error,
  output logic       busy,
  output logic       scl,
  input  logic       scl_in,
  output logic       sda_out,
  output logic       sda_out_en,
  input  logic       sda_in
);
`ifdef I2C_CLOCK_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif
  localparam logic [2:0] MSB_IDX = 3'(PHASES_BYTE / 3 - 1);
  i2c_state_t r_state;
  logic       r_scl, r_sda, r_sda_en, r_ready, r_done, r_ack_error;
  logic [7:0] r_read_byte, r_wbyte;
  logic [2:0] r_idx;
  logic       r_stop, r_read, r_nack;
  logic       w_accept, w_run, w_hold, w_phase_end;
  assign w_accept   = cmd_valid && r_ready;
  assign w_run      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_hold     = STRETCH_EN && is_stretch_phase(r_state) && !scl_in;
  assign cmd_ready  = r_ready;
  assign busy       = !r_ready;
  assign done       = r_done;
  assign ack_error  = r_ack_error;
  assign read_byte  = r_read_byte;
  assign scl        = r_scl;
  assign sda_out    = r_sda;
  assign sda_out_en = r_sda_en;
  i2c_phase_timer #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_run      (w_run),
    .i_load     (w_accept || w_phase_end),
    .i_hold     (w_hold),
    .o_phase_end(w_phase_end)
  );
  // command sequencer: each bus level is registered on entry to the phase that owns it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
      r_sda_en    <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_ack_error <= 1'b0;
      r_read_byte <= '0;
      r_wbyte     <= '0;
      r_idx       <= MSB_IDX;
      r_stop      <= 1'b0;
      r_read      <= 1'b0;
      r_nack      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_stop      <= cmd_stop;
        r_read      <= cmd_read;
        r_nack      <= cmd_nack;
        r_wbyte     <= write_byte;
        r_ack_error <= 1'b0;
        r_ready     <= 1'b0;
        r_idx       <= MSB_IDX;
        if (cmd_start) begin
          r_state  <= ST_START_A;
          r_scl    <= 1'b1;
          r_sda    <= 1'b1;
          r_sda_en <= 1'b1;
        end else begin
          r_state  <= ST_BIT_LOW;
          r_scl    <= 1'b0;
          r_sda_en <= !cmd_read;
          r_sda    <= cmd_read ? r_sda : write_byte[MSB_IDX];
        end
      end else if (r_state == ST_DONE) begin
        r_state <= ST_IDLE;
      end else if (w_phase_end) begin
        case (r_state)
          ST_START_A: begin
            r_state <= ST_START_B;
            r_sda   <= 1'b0;
          end
          ST_START_B: begin
            r_state <= ST_START_C;
            r_scl   <= 1'b0;
          end
          ST_START_C: begin
            r_state  <= ST_BIT_LOW;
            r_sda_en <= !r_read;
            r_sda    <= r_read ? r_sda : r_wbyte[r_idx];
          end
          ST_BIT_LOW: begin
            r_state <= ST_BIT_HIGH;
            r_scl   <= 1'b1;
          end
          ST_BIT_HIGH: begin
            r_state <= ST_BIT_FALL;
            r_scl   <= 1'b0;
            if (r_read) r_read_byte[r_idx] <= sda_in;
          end
          ST_BIT_FALL: begin
            if (r_idx == 3'd0) begin
              r_state  <= ST_ACK_LOW;
              r_sda_en <= r_read;
              r_sda    <= r_read ? r_nack : r_sda;
            end else begin
              r_state  <= ST_BIT_LOW;
              r_idx    <= r_idx - 1'b1;
              r_sda_en <= !r_read;
              r_sda    <= r_read ? r_sda : r_wbyte[r_idx - 1'b1];
            end
          end
          ST_ACK_LOW: begin
            r_state <= ST_ACK_HIGH;
            r_scl   <= 1'b1;
          end
          ST_ACK_HIGH: begin
            r_state <= ST_ACK_FALL;
            r_scl   <= 1'b0;
            if (!r_read && sda_in) r_ack_error <= 1'b1;
          end
          ST_ACK_FALL: begin
            if (r_stop) begin
              r_state  <= ST_STOP_A;
              r_sda_en <= 1'b1;
              r_sda    <= 1'b0;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end
          end
          ST_STOP_A: begin
            r_state <= ST_STOP_B;
            r_scl   <= 1'b1;
          end
          ST_STOP_B: begin
            r_state <= ST_STOP_C;
            r_sda   <= 1'b1;
          end
          ST_STOP_C: begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_byte.sv
// tb_i2c_master_byte: directed and random commands checked against a phase-level bus model and a timing-driven slave
module tb_i2c_master_byte;
  localparam int CLK_DIV = 4;
`ifdef I2C_CLOCK_STRETCH_EN
  localparam int STRETCH_DELAY = 50;
`else
  localparam int STRETCH_DELAY = 0;
`endif
  logic       clock = 1'b0, reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_read = 1'b0, cmd_nack = 1'b0;
  logic [7:0] write_byte = '0;
  logic       cmd_ready, done, ack_error, busy, scl, sda_out, sda_out_en;
  logic [7:0] read_byte;
  logic       scl_in, sda_in = 1'b1, stretch_low = 1'b0;
  int         cyc = 0, n_assert = 0, n_fail = 0, last_done = -1, pulses;
  logic [7:0] last_rb = '0;
  assign scl_in = scl & ~stretch_low;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  i2c_master_byte #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_nack(cmd_nack),
    .write_byte(write_byte), .read_byte(read_byte), .done(done), .ack_error(ack_error),
    .busy(busy), .scl(scl), .scl_in(scl_in), .sda_out(sda_out), .sda_out_en(sda_out_en),
    .sda_in(sda_in)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one command: expected bus levels per phase are {scl, sda_en, sda}
  task automatic run_cmd(input bit st, input bit sp, input bit rd, input bit nk, input logic [7:0] wb,
                         input logic [7:0] sb, input bit sack, input int stretch, input int abort_t,
                         input bit b2b);
    logic [2:0] ex[$];
    int pn, acc, t, p, s, w, sh;
    bit fin;
    logic [2:0] e;
    s  = st ? 3 : 0;
    pn = 27 + (st ? 3 : 0) + (sp ? 3 : 0);
    sh = (s + 1) * CLK_DIV;
    if (st) begin ex.push_back(3'b111); ex.push_back(3'b110); ex.push_back(3'b010); end
    for (int b = 7; b >= 0; b--) begin
      ex.push_back(rd ? 3'b000 : {2'b01, wb[b]});
      ex.push_back(rd ? 3'b100 : {2'b11, wb[b]});
      ex.push_back(rd ? 3'b000 : {2'b01, wb[b]});
    end
    ex.push_back(rd ? {2'b01, nk} : 3'b000);
    ex.push_back(rd ? {2'b11, nk} : 3'b100);
    ex.push_back(rd ? {2'b01, nk} : 3'b000);
    if (sp) begin ex.push_back(3'b010); ex.push_back(3'b110); ex.push_back(3'b111); end
    cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_nack = nk; write_byte = wb; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 300) begin @(negedge clock); w++; end
    check("accept_ready", cmd_ready, 1);
    acc = cyc;
    if (b2b) check("b2b_accept_in_done_cycle", acc, last_done);
    @(posedge clock); #1;
    cmd_valid = 1'b0; cmd_start = ~st; cmd_stop = ~sp; cmd_read = ~rd; cmd_nack = ~nk; write_byte = 8'($urandom);
    fin = 1'b0;
    for (int k = 0; k < pn * CLK_DIV + stretch + 20 && !fin; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      t = cyc - acc;
      p = (t - 1) / CLK_DIV;
      sda_in = (rd && p >= s && p < s + 24) ? sb[7 - (p - s) / 3] :
               (!rd && p >= s + 24 && p < s + 27) ? sack : 1'b1;
      stretch_low = (stretch > 0) && (t > sh) && (t <= sh + stretch);
      if (abort_t != 0 && t == abort_t) begin
        reset = 1'b1;
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda_en", sda_out_en, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        last_rb = '0;
        fin = 1'b1;
      end else begin
        @(negedge clock);
        if (t == 1) begin
          check("busy_after_accept", {busy, cmd_ready, done}, 3'b100);
          check("ack_error_cleared", ack_error, 0);
        end
        if (stretch == 0 && (t - 1) % CLK_DIV == CLK_DIV / 2 && p < pn) begin
          e = ex[p];
          check($sformatf("phase%0d_bus", p), {scl, sda_out_en, sda_out & sda_out_en}, {e[2], e[1], e[0] & e[1]});
        end
        if (done === 1'b1) begin
          fin = 1'b1;
          last_done = cyc;
          check("done_latency", t, pn * CLK_DIV + 1 + (stretch > 0 ? STRETCH_DELAY : 0));
          check("ready_at_done", cmd_ready, 1);
          check("ack_error_at_done", ack_error, !rd && sack);
          if (rd) last_rb = sb;
          check("read_byte_at_done", read_byte, last_rb);
        end
      end
    end
    if (!fin) check("done_timeout", 0, 1);
    stretch_low = 1'b0;
    sda_in = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {scl, sda_out, sda_out_en, cmd_ready, busy, done, ack_error}, 7'b1101000);
    check("reset_read_byte", read_byte, 0);
    reset = 1'b0;
    @(negedge clock);
    run_cmd(1, 1, 0, 0, 8'hA0, 8'h00, 1'b0, 0, 0, 0);
    run_cmd(0, 1, 1, 1, 8'h00, 8'hA5, 1'b0, 0, 0, 0);
    run_cmd(1, 1, 0, 0, 8'h55, 8'h00, 1'b1, 0, 0, 0);
    run_cmd(1, 0, 0, 0, 8'hA0, 8'h00, 1'b0, 0, 0, 0);
    run_cmd(0, 1, 1, 1, 8'h00, 8'($urandom), 1'b0, 0, 0, 1);
    run_cmd(1, 1, 0, 0, 8'($urandom), 8'h00, 1'b1, 50, 0, 0);
    run_cmd(1, 1, 0, 0, 8'hC3, 8'h00, 1'b0, 0, 62, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    pulses = 0;
    repeat (150) begin
      @(negedge clock);
      if (done === 1'b1) pulses++;
    end
    check("no_done_after_reset", pulses, 0);
    check("idle_after_reset", {cmd_ready, scl, sda_out_en, read_byte}, {3'b110, 8'h00});
    for (int i = 0; i < 8; i++)
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master_byte.md
# i2c_master_byte

Parametrised I2C byte engine for TOP2049 FPGA bottomhalves; successor to the fixed-rate per-chip I2C byte engine. It executes one command per handshake: optional START, one 8-bit write or read, an ACK/NACK bit, and optional STOP. SCL timing comes from an internal divider. Compared with the fixed engine it adds:
- master-driven ACK/NACK on reads;
- NACK reporting, with no endless ACK polling;
- optional clock stretching.

It sits between a chip's command state machine and the ZIF SDA/SCL buffers.

## Interface
- CLK_DIV, 36: clock cycles per bus phase; must be ≥2. 36 gives 1.5 µs phases at 24 MHz.
- DIV_WIDTH, 16: width of the phase counter; CLK_DIV-1 must fit.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle, can accept a command.
- cmd_start  in  1  emit START (or repeated START) first.
- cmd_stop  in  1  emit STOP last.
- cmd_read  in  1  1 = read byte, 0 = write byte.
- cmd_nack  in  1  read only: 1 = master sends NACK, 0 = ACK.
- write_byte  in  8  byte to send, MSB first.
- read_byte  out  8  last byte read; held until the next read completes.
- done  out  1  one-cycle pulse at command completion.
- ack_error  out  1  the slave NACKed the last write; valid at done, held until the next accept.
- busy  out  1  command in progress (equals !cmd_ready).
- scl  out  1  SCL drive level.
- scl_in  in  1  sampled SCL; used only with the stretch option.
- sda_out  out  1  SDA drive level.
- sda_out_en  out  1  SDA output enable.
- sda_in  in  1  sampled SDA.

## Operation
- Reset values: scl=1, sda_out=1, sda_out_en=0, cmd_ready=1, busy=0, done=0, ack_error=0, read_byte=0. The state is IDLE and the phase counter is 0.
- Accept: on a rising edge with cmd_valid && cmd_ready, all cmd_* inputs and write_byte are latched into internal registers. cmd_ready drops the next cycle. Input changes after acceptance have no effect.
- cmd_valid while busy is ignored; no queueing.
- State sequence for one command:
  - IDLE
  - if cmd_start: START_A (sda_en=1, sda=1, scl=1), START_B (sda=0), START_C (scl=0)
  - 8× {BIT_LOW, BIT_HIGH, BIT_FALL}
  - ACK_LOW, ACK_HIGH, ACK_FALL
  - if cmd_stop: STOP_A (sda_en=1, sda=0, scl=0), STOP_B (scl=1), STOP_C (sda=1)
  - DONE, then IDLE.
- Write data bits:
  - BIT_LOW drives sda = bit[idx] with sda_en=1 and scl=0.
  - BIT_HIGH sets scl=1.
  - BIT_FALL sets scl=0, then idx decrements from 7 down to 0.
- Read data bits:
  - sda_en=0 throughout.
  - sda_in is sampled into read_byte[idx] on the last cycle of BIT_HIGH.
- ACK phase after a write:
  - sda_en=0.
  - sda_in is sampled on the last cycle of ACK_HIGH; sampled 1 sets ack_error=1.
  - There is no retry. STOP is still emitted if requested.
- ACK phase after a read: sda_en=1 and sda=cmd_nack for all three ACK phases.
- DONE lasts one cycle; done=1 and cmd_ready returns to 1 in that cycle.
- IDLE holds scl and sda at their last levels, so a following command continues the transaction seamlessly.
- ack_error clears on the next accept.

## Timing
- Each state except IDLE and DONE lasts exactly CLK_DIV cycles.
  - The counter loads CLK_DIV-1 on state entry and advances the state when it reaches 0.
- Latency from the accept edge to the done pulse is P·CLK_DIV + 1 cycles, where P is the number of phases:
  - P = 27 with neither START nor STOP;
  - P = 30 with exactly one of START or STOP;
  - P = 33 with both.
- Outputs are registered and change only on state entry. The exception is read_byte bits, which update on their sample cycle.
- Reset asserted mid-command returns the engine to reset values immediately (asynchronously). No STOP is generated.
- Back-to-back: a command presented during DONE is accepted in that same cycle. The bus is never left idle between commands.

## Configuration
- I2C_CLOCK_STRETCH_EN defined:
  - In START_A, BIT_HIGH, ACK_HIGH and STOP_B the phase counter holds while scl_in==0.
  - The phase therefore lasts CLK_DIV cycles counted after scl_in is seen high.
  - The stretch is unbounded.
- I2C_CLOCK_STRETCH_EN undefined: scl_in is ignored and phase lengths are fixed.

## Structure
- Shared package i2c_pkg:
  - state enumeration;
  - constants PHASES_START=3, PHASES_BYTE=24, PHASES_ACK=3, PHASES_STOP=3.
- Sub-module i2c_phase_timer: CLK_DIV counter plus the stretch hold; outputs a phase_end pulse.
- The top holds the state machine, bit index, shift and latch registers.

## Test plan
- CLK_DIV=4, write 0xA0 with start+stop, slave ACKs → SDA bits 1,0,1,0,0,0,0,0 at the SCL rising edges; ack_error=0; done pulses 133 cycles after the accept.
- Read with stop and cmd_nack=1, slave drives 0xA5 → read_byte=0xA5; master drives SDA=1 during ACK_HIGH; done after 121 cycles.
- Write 0x55 with sda_in held at 1 → ack_error=1 at done; STOP emitted; the next accept clears ack_error.
- Reset asserted at bit 3 of a write → next cycle scl=1, sda_out_en=0, cmd_ready=1, done=0; no done pulse follows.
- Back-to-back: write 0xA0 with start, then read (nack, stop) presented during DONE → second accept in the DONE cycle; no extra START.
- With I2C_CLOCK_STRETCH_EN, scl_in held low 50 cycles during the BIT_HIGH of bit 7 → done is delayed by exactly 50 cycles versus the unstretched run. Without the macro, the delay is 0.
